// File: rtl/write_controller_if.sv
// Producer/memory-side signal bundle of the FIFO write controller.
// The controller takes the slave view; the producer/test environment takes master.
interface write_controller_if #(
    parameter int ADDR_WIDTH = 5
);
    localparam int PW = ADDR_WIDTH + 1;

    logic                  write;      // write request from producer
    logic [PW-1:0]         rptrs;      // Gray read pointer, already in clkw domain
    logic [PW-1:0]         wptr;       // Gray write pointer toward read domain
    logic [ADDR_WIDTH-1:0] waddr;      // memory write address
    logic                  wen;        // memory write enable
    logic                  fullflag;   // FIFO full
    logic                  almostfull; // fill level at or above threshold
    logic [PW-1:0]         level;      // fill level 0..2^ADDR_WIDTH
    logic                  overflow;   // sticky write-while-full error

    modport master (
        output write, rptrs,
        input  wptr, waddr, wen, fullflag, almostfull, level, overflow
    );

    modport slave (
        input  write, rptrs,
        output wptr, waddr, wen, fullflag, almostfull, level, overflow
    );
endinterface

// File: rtl/write_controller.sv
// Write-side pointer/flag logic of an asynchronous FIFO.
// Keeps a binary write pointer, publishes its Gray form, and derives
// full / almost-full / fill level from the synchronized Gray read pointer.
module write_controller #(
    parameter int ADDR_WIDTH  = 5,
    parameter int AFULL_LEVEL = 28
) (
    input  logic              clkw,
    input  logic              resetw,
    write_controller_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW:0] AFULL_THR = (PW + 1)'(AFULL_LEVEL);

    logic [PW-1:0] wbin_reg;
    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] level_reg;
    logic          full_reg;
    logic          afull_reg;
    logic          ovf_reg;

    logic          accept;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          afull_next;

    // Reset gates the enable so no memory write slips through a reset cycle.
    assign accept = bus.write & ~full_reg & ~resetw;

    // Binary read pointer: each bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign rbin[gi] = ^bus.rptrs[PW-1:gi];
        end
    endgenerate

    // Next pointer, its Gray form, and the flags derived from it.
    always_comb begin
        wbin_next  = wbin_reg + {{(PW-1){1'b0}}, accept};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        // Full when the Gray pointers differ only in their two top bits,
        // i.e. the writer is exactly one lap ahead of the reader.
        full_next  = (wgray_next == {~bus.rptrs[PW-1:PW-2], bus.rptrs[PW-3:0]});
        level_next = wbin_next - rbin;
        afull_next = ({1'b0, level_next} >= AFULL_THR);
    end

    // Pointer, flag and level registers; overflow is sticky until reset.
    always_ff @(posedge clkw) begin
        if (resetw) begin
            wbin_reg  <= '0;
            wptr_reg  <= '0;
            level_reg <= '0;
            full_reg  <= 1'b0;
            afull_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            wbin_reg  <= wbin_next;
            wptr_reg  <= wgray_next;
            level_reg <= level_next;
            full_reg  <= full_next;
            afull_reg <= afull_next;
            ovf_reg   <= ovf_reg | (bus.write & full_reg);
        end
    end

    // waddr is the pre-increment pointer, so data lands where wen points.
    assign bus.wen        = accept;
    assign bus.waddr      = wbin_reg[ADDR_WIDTH-1:0];
    assign bus.wptr       = wptr_reg;
    assign bus.fullflag   = full_reg;
    assign bus.almostfull = afull_reg;
    assign bus.level      = level_reg;
    assign bus.overflow   = ovf_reg;
endmodule

// File: tb/tb_write_controller.sv
// Self-checking bench for write_controller: directed scenarios plus random
// traffic, compared against a count-based FIFO occupancy model.
module tb_write_controller;
    logic clkw = 1'b0;
    logic resetw;

    write_controller_if #(.ADDR_WIDTH(5)) bus ();

    write_controller #(.ADDR_WIDTH(5), .AFULL_LEVEL(28)) dut (
        .clkw   (clkw),
        .resetw (resetw),
        .bus    (bus)
    );

    always #5 clkw = ~clkw;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: total accepted writes and reads since reset.
    int   wcnt;
    int   rcnt;
    logic m_full;
    logic m_af;
    int   m_level;
    logic m_ovf;
    int   wen_cnt;
    int   txn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s txn=%0d got=%0h exp=%0h", tag, txn, got, exp);
        end
    endtask

    function automatic logic [5:0] gray6(input int b);
        logic [5:0] v;
        v = 6'(b & 63);
        return v ^ (v >> 1);
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, check registers.
    task automatic step(input logic wr, input logic rst, input int rc);
        logic exp_wen;
        int   lvl;
        bus.write = wr;
        resetw    = rst;
        rcnt      = rc;
        bus.rptrs = gray6(rc);
        #1;
        exp_wen = wr && !m_full && !rst;
        check("wen", 32'(bus.wen), 32'(exp_wen));
        if (exp_wen) check("waddr", 32'(bus.waddr), 32'(wcnt % 32));
        if (bus.wen) wen_cnt++;
        @(posedge clkw);
        #1;
        if (rst) begin
            wcnt = 0; m_full = 0; m_af = 0; m_level = 0; m_ovf = 0;
        end else begin
            if (wr && m_full) m_ovf = 1;
            if (exp_wen) wcnt++;
            lvl     = (wcnt - rc) & 63;
            m_level = lvl;
            m_full  = (lvl == 32);
            m_af    = (lvl >= 28);
        end
        check("wptr", 32'(bus.wptr), 32'(gray6(wcnt)));
        check("fullflag", 32'(bus.fullflag), 32'(m_full));
        check("almostfull", 32'(bus.almostfull), 32'(m_af));
        check("level", 32'(bus.level), 32'(m_level));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        $display("txn %0d rst=%0b wr=%0b rptrs=%b wen=%0b wptr=%b full=%0b af=%0b lvl=%0d ovf=%0b",
                 txn, rst, wr, bus.rptrs, exp_wen, bus.wptr, bus.fullflag,
                 bus.almostfull, bus.level, bus.overflow);
        txn++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog txn=%0d", txn);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc;
        wcnt = 0; rcnt = 0; m_full = 0; m_af = 0; m_level = 0; m_ovf = 0;
        wen_cnt = 0; txn = 0;

        // Reset with a write pending: nothing may be accepted.
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 0);

        // Fill from empty: 32 accepted writes, full on the last one.
        wen_cnt = 0;
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 0);
        check("fill_wen_count", 32'(wen_cnt), 32'd32);
        check("fill_wptr", 32'(bus.wptr), 32'b110000);

        // Writes while full: rejected, overflow sticks.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
        check("ovf_wptr", 32'(bus.wptr), 32'b110000);

        // Idle while full: flags hold.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0);

        // One read frees a slot; the next write refills it at address 0.
        step(1'b0, 1'b0, 1);
        step(1'b1, 1'b0, 1);
        check("refill_full", 32'(bus.fullflag), 32'd1);

        // Reset while full and overflowed.
        step(1'b1, 1'b1, 1);

        // Wrap: reader trails by one, level stays 1 across 63 -> 0.
        for (int i = 0; i < 70; i++) begin
            step(1'b1, 1'b0, wcnt);
            step(1'b0, 1'b0, wcnt - 1);
            check("wrap_level", 32'(bus.level), 32'd1);
        end

        // Random traffic with occasional resets.
        rc = rcnt;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                step(1'b1, 1'b1, 0);
                rc = 0;
            end else begin
                if (i % 100 < 50) rc = rc + int'($urandom_range(0, 1));
                else              rc = rc + int'($urandom_range(0, 2));
                if (rc > wcnt) rc = wcnt;
                step(($urandom_range(0, 3) != 0), 1'b0, rc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/write_controller.md
WRITE_CONTROLLER -- requirements
Module: write_controller

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, memory address width; pointer width PW = ADDR_WIDTH+1 (6 by default, depth 32).
REQ-002 Parameter AFULL_LEVEL, default 28, fill level at or above which almostfull asserts; legal range 1..2^ADDR_WIDTH.
REQ-003 clkw  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 resetw  input  1  reset, synchronous, active-high.
REQ-005 write  input  1  write request from producer, sampled each clkw rising edge.
REQ-006 rptrs  input  PW  read pointer, Gray-coded, already synchronized into clkw domain.
REQ-007 wptr  output  PW  registered write pointer, Gray-coded, sent to read domain.
REQ-008 waddr  output  ADDR_WIDTH  memory write address = low ADDR_WIDTH bits of binary write pointer.
REQ-009 wen  output  1  memory write enable, combinational = write & ~fullflag.
REQ-010 fullflag  output  1  registered FIFO-full indication.
REQ-011 almostfull  output  1  registered, level >= AFULL_LEVEL.
REQ-012 level  output  PW  registered fill level, 0..2^ADDR_WIDTH.
REQ-013 overflow  output  1  sticky error: write requested while full.

Function
REQ-014 Internal binary pointer wbin (PW bits); wptr SHALL equal registered bin2gray(wbin) (wbin ^ (wbin>>1)).
REQ-015 Write accepted iff write=1 and fullflag=0 at the rising edge; accepted write increments wbin by 1, modulo 2^PW (63 -> 0 wraps, no saturation).
REQ-016 waddr SHALL present current wbin low bits in the cycle wen is high, so data lands at the pre-increment address.
REQ-017 wgnext = bin2gray(wbin + accept); fullflag register <= (wgnext == {~rptrs[PW-1:PW-2], rptrs[PW-3:0]}); evaluated every cycle.
REQ-018 fullflag asserts on the same edge that accepts the write filling the last slot (zero extra latency).
REQ-019 fullflag deasserts on the first edge at which the rptrs change is sampled (one-cycle latency from rptrs change); no write accepted in that intervening cycle.
REQ-020 rbin = gray2bin(rptrs) (combinational prefix XOR); level register <= (wbin + accept) - rbin, modulo 2^PW.
REQ-021 almostfull register <= (next level >= AFULL_LEVEL), same edge as level.
REQ-022 write=1 while fullflag=1: wen=0, wbin/wptr unchanged, overflow <= 1; overflow stays 1 until reset.
REQ-023 write=0: wbin, wptr unchanged; fullflag/level/almostfull still recompute from rptrs each cycle.
REQ-024 Pointer compare is pure Gray; no binary conversion of wptr crosses domains.

Reset
REQ-025 resetw=1 at a rising edge: wbin=0, wptr=0, fullflag=0, almostfull=0, level=0, overflow=0, regardless of write or rptrs.
REQ-026 Reset dominates simultaneous write; wen SHALL be forced 0 while resetw=1.
REQ-027 Reset mid-operation discards pointer state; read domain is reset by the team's same reset sequencing, not by this block.

Verification
REQ-028 Reset, rptrs=0, write=1 for 32 edges -> wptr=6'b110000, fullflag=1 on 32nd edge, level=32, almostfull=1 from 28th edge, wen high exactly 32 cycles, waddr 0..31.
REQ-029 Full, write=1 one more edge -> wen=0, wptr stays 6'b110000, overflow=1 and stays 1 through later writes.
REQ-030 Full, rptrs -> 6'b000001 (gray of 1) -> fullflag=0 and level=31 on next edge; following write accepted, waddr=0, fullflag=1 again.
REQ-031 Wrap: alternate writes with rptrs tracking to wbin-1 over 70 writes -> wbin passes 63 -> 0, wptr 6'b100000 -> 6'b000000, fullflag never asserts, level stays 1.
REQ-032 resetw=1 with write=1, fullflag=1, overflow=1 -> next edge all outputs 0, wen=0 during reset cycle.
REQ-033 Boundary: rptrs=6'b000000, wptr=6'b110000 steady, write=0 for 10 cycles -> fullflag holds 1, level holds 32.
